// File: rtl/chroma_upsampler_pkg.sv
// chroma_upsampler_pkg: shared block type, subsampling modes and FSM states
package chroma_upsampler_pkg;
  localparam int DATA_W_D = 8;
  localparam int BLK_D = 8;
  localparam int CH_D = 3;
  typedef logic [BLK_D-1:0][BLK_D-1:0][DATA_W_D-1:0] pix_blk_t;
  typedef enum logic [1:0] {SS_444, SS_422, SS_420, SS_RSVD} ss_mode_e;
  typedef enum logic {IDLE, EMIT} state_e;
endpackage

// File: rtl/upsample_select.sv
// upsample_select: pixel-replication mux picking sub-block cnt of the held block
module upsample_select
  import chroma_upsampler_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BLK = 8
) (
  input  logic [BLK-1:0][BLK-1:0][DATA_W-1:0] hold,
  input  ss_mode_e                            mode,
  input  logic [1:0]                          cnt,
  output logic [BLK-1:0][BLK-1:0][DATA_W-1:0] out_block
);
  localparam int H = BLK / 2;
  for (genvar r = 0; r < BLK; r++) begin : g_r
    for (genvar c = 0; c < BLK; c++) begin : g_c
      logic [DATA_W-1:0] p420, p422;
      assign p420 = cnt[1] ? (cnt[0] ? hold[H+r/2][H+c/2] : hold[H+r/2][c/2])
                           : (cnt[0] ? hold[r/2][H+c/2]   : hold[r/2][c/2]);
      assign p422 = cnt[0] ? hold[r][H+c/2] : hold[r][c/2];
      assign out_block[r][c] = mode == SS_420 ? p420 : mode == SS_422 ? p422 : hold[r][c];
    end
  end
endmodule

// File: rtl/chroma_upsampler.sv
// chroma_upsampler: buffers one block and emits 1, 2 or 4 replicated sub-blocks
module chroma_upsampler
  import chroma_upsampler_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BLK = 8,
  parameter int CH = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [$clog2(CH+1)-1:0]             in_ch,
  input  logic [1:0]                          in_mode,
  input  logic [BLK-1:0][BLK-1:0][DATA_W-1:0] in_block,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [BLK-1:0][BLK-1:0][DATA_W-1:0] out_block,
  output logic [$clog2(CH+1)-1:0]             out_ch,
  output logic [1:0]                          out_idx,
  output logic                                out_last,
  output logic                                err
);
  localparam int CW = $clog2(CH + 1);
  localparam logic [CW-1:0] CH_LIM = CW'(CH);
  logic [BLK-1:0][BLK-1:0][DATA_W-1:0] hold;
  state_e state;
  ss_mode_e mode, eff;
  logic [1:0] cnt, last_cnt;
  logic acc, legal, beat;
  always_comb begin
    eff = (in_ch == '0 || in_mode == 2'd3) ? SS_444 : ss_mode_e'(in_mode);
    legal = in_ch < CH_LIM;
    last_cnt = mode == SS_420 ? 2'd3 : mode == SS_422 ? 2'd1 : 2'd0;
    out_valid = state == EMIT;
    out_last = out_valid && cnt == last_cnt;
    out_idx = mode == SS_420 ? cnt : mode == SS_422 ? {1'b0, cnt[0]} : 2'd0;
    beat = out_valid && out_ready;
    in_ready = state == IDLE || (beat && out_last);
    acc = in_valid && in_ready;
  end
  // illegal channels are consumed without touching the holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hold <= '0;
      mode <= SS_444;
      cnt <= 2'd0;
      out_ch <= '0;
      err <= 1'b0;
    end else begin
      err <= acc && !legal;
      if (acc && legal) begin
        hold <= in_block;
        out_ch <= in_ch;
        mode <= eff;
        cnt <= 2'd0;
        state <= EMIT;
      end else if (beat) begin
        cnt <= out_last ? 2'd0 : cnt + 2'd1;
        if (out_last) state <= IDLE;
      end
    end
  end
  upsample_select #(.DATA_W(DATA_W), .BLK(BLK)) u_sel (
    .hold(hold),
    .mode(mode),
    .cnt(cnt),
    .out_block(out_block)
  );
endmodule

// File: tb/tb_chroma_upsampler.sv
// tb_chroma_upsampler: directed checks of replication, handshakes, errors and reset
module tb_chroma_upsampler;
  import chroma_upsampler_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_last, err;
  logic [1:0] in_ch = '0, out_ch, in_mode = '0, out_idx;
  pix_blk_t in_block = '0, out_block, ramp, exp_blk;
  int n_pass = 0, n_total = 0, n_fail = 0;

  chroma_upsampler #(.DATA_W(8), .BLK(8), .CH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_mode(in_mode),
    .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
    .out_ch(out_ch), .out_idx(out_idx), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic pix_blk_t mk(input int k);
    pix_blk_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) b[r][c] = 8'(r * 8 + c + k * 64);
    return b;
  endfunction

  initial begin
    ramp = mk(0);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_err", err, 0);
    chk("rst_block", out_block, 0);
    #10 rst = 1'b1;
    step();
    // luma: mode 2 forced to 4:4:4
    in_block = ramp; in_ch = 2'd0; in_mode = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("y_valid", out_valid, 1);
    chk("y_idx", out_idx, 0);
    chk("y_last", out_last, 1);
    chk("y_block", out_block, ramp);
    step();
    chk("y_done", out_valid, 0);
    // 4:2:0 Cb, inputs wiggled during emission
    in_ch = 2'd1; in_mode = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_ch = 2'd2; in_mode = 2'd0;
    chk("c420_i0_idx", out_idx, 0);
    chk("c420_i0_last", out_last, 0);
    chk("c420_i0_ch", out_ch, 1);
    chk("c420_i0_p77", out_block[7][7], 27);
    step();
    chk("c420_i1_idx", out_idx, 1);
    chk("c420_i1_p12", out_block[1][2], 5);
    chk("c420_i1_ch", out_ch, 1);
    step();
    chk("c420_i2_idx", out_idx, 2);
    chk("c420_i2_last", out_last, 0);
    chk("c420_i2_p00", out_block[0][0], 32);
    step();
    chk("c420_i3_idx", out_idx, 3);
    chk("c420_i3_last", out_last, 1);
    chk("c420_i3_p00", out_block[0][0], 36);
    chk("c420_i3_p77", out_block[7][7], 63);
    step();
    chk("c420_done", out_valid, 0);
    // 4:2:2 Cr with a stall on idx 0
    in_ch = 2'd2; in_mode = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("c422_i0_idx", out_idx, 0);
    chk("c422_i0_p30", out_block[3][0], 24);
    chk("c422_i0_ch", out_ch, 2);
    #1 chk("c422_stall_in_ready", in_ready, 0);
    step();
    chk("c422_hold_valid", out_valid, 1);
    chk("c422_hold_idx", out_idx, 0);
    chk("c422_hold_last", out_last, 0);
    chk("c422_hold_p30", out_block[3][0], 24);
    out_ready = 1'b1;
    step();
    chk("c422_i1_idx", out_idx, 1);
    chk("c422_i1_last", out_last, 1);
    chk("c422_i1_p30", out_block[3][0], 28);
    chk("c422_i1_p37", out_block[3][7], 31);
    step();
    chk("c422_done", out_valid, 0);
    // back-to-back 4:4:4 Cb
    in_ch = 2'd1; in_mode = 2'd0; in_valid = 1'b1; in_block = mk(1);
    step();
    chk("b2b0_block", out_block, mk(1));
    chk("b2b0_in_ready", in_ready, 1);
    in_block = mk(2);
    step();
    chk("b2b1_block", out_block, mk(2));
    chk("b2b1_valid", out_valid, 1);
    chk("b2b1_in_ready", in_ready, 1);
    in_block = mk(3);
    step();
    chk("b2b2_block", out_block, mk(3));
    chk("b2b2_last", out_last, 1);
    in_valid = 1'b0;
    step();
    chk("b2b_done", out_valid, 0);
    // illegal channel
    in_ch = 2'd3; in_mode = 2'd0; in_valid = 1'b1; in_block = ramp;
    step();
    in_valid = 1'b0;
    chk("ill_err", err, 1);
    chk("ill_valid", out_valid, 0);
    step();
    chk("ill_err_clr", err, 0);
    chk("ill_valid2", out_valid, 0);
    // reserved mode on Cb
    in_ch = 2'd1; in_mode = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rsv_idx", out_idx, 0);
    chk("rsv_last", out_last, 1);
    chk("rsv_block", out_block, ramp);
    step();
    chk("rsv_done", out_valid, 0);
    // reset after idx 1 of a 4:2:0 block
    in_ch = 2'd1; in_mode = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_idx", out_idx, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_block", out_block, 0);
    chk("mid_rst_idx", out_idx, 0);
    chk("mid_rst_ch", out_ch, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    #1 rst = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_idx", out_idx, 0);
    chk("post_rst_p77", out_block[7][7], 27);
    step();
    chk("post_rst_idx1", out_idx, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/chroma_upsampler.md
# chroma_upsampler

Parametrised, handshaked successor to the fixed 4:2:0 supersampler. It sits between the IDCT/level-shift stage and colour conversion. It accepts one decoded 8x8-class block per transfer, buffers it, and emits 1, 2 or 4 full-resolution blocks by pixel replication, according to a per-block subsampling mode. Both sides use valid/ready, so downstream backpressure stalls the block without dropping data.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- BLK, 8, block edge in pixels; must be even and at least 2
- CH, `CH, number of colour channels; channel 0 is luma

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input block present
- in_ready  out  1  block accepted when in_valid && in_ready
- in_ch  in  $clog2(CH+1)  channel of the input block
- in_mode  in  2  subsampling mode: 0 = 4:4:4, 1 = 4:2:2 (horizontal), 2 = 4:2:0, 3 = reserved
- in_block  in  DATA_W x BLK x BLK  input pixels, indexed [row][col]
- out_valid  out  1  output block present
- out_ready  in  1  downstream accepts the output block
- out_block  out  DATA_W x BLK x BLK  upsampled block
- out_ch  out  $clog2(CH+1)  channel of the emitted block
- out_idx  out  2  sub-block index; bit0 = column half, bit1 = row half
- out_last  out  1  final sub-block of this input
- err  out  1  one-cycle pulse when an illegal in_ch is accepted

## Operation
- States: IDLE, EMIT.
- Acceptance (IDLE, in_valid):
  - Latch in_block, in_ch and the effective mode into the holding register.
  - Set cnt = 0 and compute total.
  - Go to EMIT.
- Effective mode:
  - in_ch == 0 is always forced to 4:4:4.
  - in_mode == 3 is treated as 4:4:4.
- total (number of sub-blocks emitted): 4:4:4 = 1, 4:2:2 = 2, 4:2:0 = 4.
- Sub-block pixel mapping, for sub-block k = cnt, pixel (r, c), with H = BLK/2:
  - 4:4:4: out[r][c] = buf[r][c]
  - 4:2:2: out[r][c] = buf[r][k[0]*H + c/2]
  - 4:2:0: out[r][c] = buf[k[1]*H + r/2][k[0]*H + c/2]
- Output fields:
  - out_idx = cnt for 4:2:0. For 4:2:2 it is {1'b0, cnt[0]}. For 4:4:4 it is 0.
  - out_last = (cnt == total-1).
- EMIT:
  - out_valid = 1.
  - On out_valid && out_ready, cnt increments.
  - On the last beat the block returns to IDLE, or reloads directly if in_valid is high (see in_ready).
- Illegal channel (in_ch >= CH):
  - The block is accepted and discarded, and err pulses in the cycle after acceptance.
  - Nothing is emitted and the state stays IDLE.
- Arithmetic: index math only; pixel values are never modified. Divides are right-shifts of the row/column index.

## Timing
- Reset values:
  - State IDLE, cnt 0, in_ready 1, out_valid 0, out_last 0, out_idx 0, out_ch 0, err 0.
  - out_block and the holding register are all zero.
- Latency: a block accepted at edge N drives out_valid = 1, with the first sub-block, in the cycle after edge N.
- Throughput:
  - One sub-block per cycle while out_ready is held high.
  - With back-to-back inputs and out_ready high, a 4:2:0 input is accepted once every 4 cycles, 4:2:2 once every 2 and 4:4:4 every cycle. There are no bubbles.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). It is combinational from out_ready; no other combinational paths exist.
- Stability: out_block, out_ch, out_idx and out_last stay stable while out_valid && !out_ready.
- Mid-operation changes: in_mode and in_ch changing during EMIT has no effect, because values are sampled only at acceptance.
- Reset mid-EMIT: asynchronous return to IDLE. The remaining sub-blocks are lost and out_valid falls immediately.
- Simultaneous last-beat and new input: the new block is accepted in the same cycle, and its first sub-block follows in the next cycle.

## Structure
- Shared package (`sys_defs.svh` / pkg):
  - typedef for the pixel block, DATA_W x BLK x BLK.
  - enum ss_mode_e { SS_444, SS_422, SS_420, SS_RSVD }.
  - FSM state enum.
- One sub-module, upsample_select: purely combinational (buf, mode, cnt) -> out_block per the mapping above. The top module holds the FSM, counter and holding register.

## Test plan
- Luma passthrough: Y block with pixel value = r*8+c, mode 2, out_ready = 1. Expect exactly one output with out_idx 0, out_last 1 and pixels equal to the input.
- 4:2:0 Cb: in[r][c] = r*8+c.
  - Expect 4 outputs on consecutive cycles with out_idx 0,1,2,3, out_last only on idx 3 and out_ch 1.
  - idx 3: out[0][0] = 36 and out[7][7] = 63. idx 1: out[1][2] = 5.
- 4:2:2 Cr with out_ready toggling 1,0,1: expect 2 outputs, idx 0 then 1, held stable during the stall. idx 1: out[3][0] = 28.
- Back-to-back: three 4:4:4 Cb blocks with out_ready high. Expect in_ready continuously 1 and three outputs on consecutive cycles.
- Illegal and reserved inputs:
  - in_ch = CH: expect err pulse one cycle after acceptance and no out_valid.
  - in_mode = 3 on Cb: expect a single 4:4:4 output.
- Reset while in EMIT after idx 1 of a 4:2:0 block: expect out_valid = 0 immediately and all outputs at reset values. The next block starts at idx 0.
